attitude_search_seq: RTL and testbench
======================================

Name: attitude_search_seq

Overview:
- Parametrised successor to the coarse-to-fine angle search state machine.
- Generates (theta, phi, alpha) test points for the downstream scorer. Stage 0 is a coarse full-range grid. Each later stage does a refined local sweep around the NUM_CAND sorted candidates, with the step halved per stage.
- Adds configurable depth and width, a valid/ready point handshake, clamp-or-wrap window edges, abort, and per-stage completion strobes.

Parameters:
- ANG_W, 12, angle width; angles span 0..2^ANG_W-1.
- NUM_CAND, 10, candidates refined per stage (>=1).
- NUM_STAGE, 3, total stages including stage 0; must satisfy NUM_STAGE-1 <= STEP0_SHIFT.
- STEP0_SHIFT, 8, stage-0 step is 2^STEP0_SHIFT.
- WRAP, 0, window edges: 0 = clamp to [0, 2^ANG_W-1]; 1 = modulo 2^ANG_W.
- CNT_W, 16, width of point_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  level; sampled only in IDLE
- abort  in  1  synchronous; returns to IDLE from any state
- sorted_rdy  in  1  one-cycle strobe: candidate buffer valid for next stage
- candidate_angle_buffer  in  NUM_CAND*3*ANG_W  candidate i = bits [3*ANG_W*(i+1)-1 -: 3*ANG_W], packed {theta,phi,alpha} MSB-first
- point_rdy  in  1  downstream accepts point
- point_vld  out  1  theta/phi/alpha valid
- theta, phi, alpha  out  ANG_W each  current point
- stage  out  clog2(NUM_STAGE)  current stage index
- cand_idx  out  clog2(NUM_CAND)  candidate being refined (0 in stage 0)
- point_cnt  out  CNT_W  points accepted in current stage; wraps at 2^CNT_W
- stage_done  out  1  one-cycle pulse at end of each non-final stage
- done  out  1  one-cycle pulse after final stage
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal candidate latch cleared.
- States: IDLE, SWEEP, WAIT_SORT, DONE.
- IDLE, start=1: load stage 0 (min=0 on all axes, step S0=2^STEP0_SHIFT, 2^(ANG_W-STEP0_SHIFT) points per axis); stage=0, point_cnt=0. Next cycle enter SWEEP.
- SWEEP: point_vld=1 and outputs are registered.
  - Advance only on point_vld & point_rdy. Order is alpha innermost, then phi, then theta, then cand_idx.
  - point_cnt increments on each handshake.
  - With point_rdy=0, all outputs hold stable.
- Stage s>=1 setup, per axis centre c: half-width w = S0>>(s-1), step = S0>>s.
  - WRAP=1: exactly 5 points: c-w, c-w+step, c, c+w-step, c+w, mod 2^ANG_W.
  - WRAP=0: min = max(c-w,0) and max = min(c+w,2^ANG_W-1), computed in ANG_W+1 bits. Points are min+k*step; the axis ends when cur+step > max.
- Moving to the next candidate reloads all three axes from candidate cand_idx+1 in the same cycle as the handshake. There is no bubble; point_vld stays high.
- Handshake on the last point of a stage:
  - Non-final stage: point_vld=0, stage_done=1 for one cycle, enter WAIT_SORT.
  - Final stage: enter DONE.
- WAIT_SORT: point_vld=0. On sorted_rdy, latch the candidate buffer, stage+1, cand_idx=0, point_cnt=0, load candidate 0 window; enter SWEEP next cycle. The buffer is sampled only on that edge.
- DONE: done=1 for one cycle, then IDLE. busy falls with entry to IDLE.
- sorted_rdy is ignored outside WAIT_SORT. start is ignored outside IDLE.
- abort has priority over every transition in the same cycle. It gives IDLE and clears outputs, with no stage_done or done pulse.
- Reset mid-operation gives immediate IDLE; a new start re-runs from stage 0.

Test Plan:
- Reset then idle, start=0 for 10 cycles -> point_vld=busy=stage_done=done=0; theta=phi=alpha=0.
- Stage 0, defaults, point_rdy=1:
  - First point (0,0,0) one cycle after start.
  - Second point (0,0,256).
  - Last point (3840,3840,3840) at point_cnt 4095.
  - stage_done one cycle after the 4096th handshake.
- Stage 1, all candidates (2048,2048,2048), sorted_rdy pulse:
  - theta sequence 1792,1920,2048,2176,2304.
  - 125 points per candidate; cand_idx 0..9; 1250 points total; then stage_done.
- Edge case, candidate 0 = (0,0,4095) in stage 1:
  - WRAP=0: theta/phi values 0,128,256 and alpha values 3839,3967,4095; 27 points.
  - WRAP=1: theta values 3840,3968,0,128,256; 125 points.
- Backpressure: toggle point_rdy pseudo-randomly -> outputs stable while not ready; no points skipped or repeated; point_cnt equals handshake count.
- Abort and reset:
  - abort in mid stage-1 -> IDLE next cycle, no done.
  - rst=0 in mid-sweep -> outputs 0 immediately.
  - Full 3-stage run -> single done pulse, busy drops next cycle.

Source files
------------

// File: rtl/attitude_search_seq.sv
// -----------------------------------------------------------------------------
// attitude_search_seq
//
// Coarse-to-fine (theta, phi, alpha) test-point generator for the downstream
// scorer. Stage 0 walks a coarse full-range grid. Each later stage walks a
// local 5-point-per-axis window around each of NUM_CAND sorted candidates, and
// the step halves from one stage to the next. Window edges are either clamped
// to the angle range (WRAP=0) or taken modulo 2^ANG_W (WRAP=1).
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   start                   : level, sampled only in IDLE
//   abort                   : synchronous return to IDLE, highest priority
//   sorted_rdy              : strobe, candidate buffer valid for the next stage
//   candidate_angle_buffer  : NUM_CAND x {theta,phi,alpha}, candidate 0 in LSBs
//   point_rdy / point_vld   : point handshake
//   theta, phi, alpha       : current point
//   stage, cand_idx         : current stage / candidate being refined
//   point_cnt               : points accepted in the current stage
//   stage_done, done        : end-of-stage / end-of-search pulses
//   busy                    : high whenever not IDLE
// -----------------------------------------------------------------------------
module attitude_search_seq #(
  parameter int ANG_W       = 12,
  parameter int NUM_CAND    = 10,
  parameter int NUM_STAGE   = 3,
  parameter int STEP0_SHIFT = 8,
  parameter int WRAP        = 0,
  parameter int CNT_W       = 16,
  localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1,
  localparam int CW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        sorted_rdy,
  input  logic [NUM_CAND*3*ANG_W-1:0] candidate_angle_buffer,
  input  logic                        point_rdy,
  output logic                        point_vld,
  output logic [ANG_W-1:0]            theta,
  output logic [ANG_W-1:0]            phi,
  output logic [ANG_W-1:0]            alpha,
  output logic [SW-1:0]               stage,
  output logic [CW-1:0]               cand_idx,
  output logic [CNT_W-1:0]            point_cnt,
  output logic                        stage_done,
  output logic                        done,
  output logic                        busy
);

  localparam int CAND_W = 3 * ANG_W;
  localparam logic [ANG_W:0] MAX_A = {1'b0, {ANG_W{1'b1}}};
  localparam logic [ANG_W:0] S0    = {{ANG_W{1'b0}}, 1'b1} << STEP0_SHIFT;

  typedef enum logic [1:0] {IDLE, SWEEP, WAIT_SORT, DONE} state_t;

  // One sweep axis: current value, window start (reload value on carry),
  // window end, and the point index used to end a 5-point wrapped window.
  typedef struct packed {
    logic [ANG_W-1:0] cur;
    logic [ANG_W-1:0] lo;
    logic [ANG_W-1:0] hi;
    logic [2:0]       k;
  } axis_t;

  // Index 2 = theta, 1 = phi, 0 = alpha, matching the candidate packing.
  axis_t [2:0]              ax_q, ax_d;
  state_t                   state_q, state_d;
  logic [ANG_W:0]           step_q, step_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [CW-1:0]            cand_q, cand_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     stage_done_q, stage_done_d;
  logic [NUM_CAND*CAND_W-1:0] buf_q, buf_d;

  logic [ANG_W:0]           nxt [3];
  logic [2:0]               last;
  logic                     carry;
  logic [CAND_W-1:0]        cword;

  // Window around centre c for stage s >= 1: half-width S0>>(s-1). Bounds
  // are formed one bit wider so the clamp sees underflow/overflow.
  function automatic axis_t load_axis(input logic [ANG_W-1:0] c, input int s);
    axis_t          a;
    logic [ANG_W:0] w, sum;
    w     = S0 >> (s - 1);
    sum   = {1'b0, c} + w;
    a.lo  = (WRAP == 0 && {1'b0, c} < w) ? '0 : c - w[ANG_W-1:0];
    a.hi  = (WRAP == 0 && sum > MAX_A) ? MAX_A[ANG_W-1:0] : sum[ANG_W-1:0];
    a.cur = a.lo;
    a.k   = '0;
    return a;
  endfunction

  function automatic logic [CAND_W-1:0] cand_word(
    input logic [NUM_CAND*CAND_W-1:0] b, input int i);
    return b[CAND_W*i +: CAND_W];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct here
    // because this block is purely combinational.
    state_d      = state_q;
    ax_d         = ax_q;
    step_d       = step_q;
    stage_d      = stage_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    stage_done_d = 1'b0;
    buf_d        = buf_q;
    carry        = 1'b0;
    cword        = '0;

    for (int i = 0; i < 3; i++) begin
      nxt[i] = {1'b0, ax_q[i].cur} + step_q;
      // Wrapped windows are exactly 5 points; clamped ones and the stage-0
      // grid end when the next step would pass the window end.
      last[i] = (WRAP != 0 && stage_q != '0) ? (ax_q[i].k == 3'd4)
                                             : (nxt[i] > {1'b0, ax_q[i].hi});
    end

    if (abort) begin
      state_d = IDLE;
      ax_d    = '0;
      stage_d = '0;
      cand_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SWEEP;
            for (int i = 0; i < 3; i++) begin
              ax_d[i] = '{cur: '0, lo: '0, hi: MAX_A[ANG_W-1:0], k: '0};
            end
            step_d  = S0;
            stage_d = '0;
            cand_d  = '0;
            cnt_d   = '0;
          end
        end

        SWEEP: begin
          if (point_rdy) begin
            cnt_d = cnt_q + 1'b1;
            // Odometer: alpha innermost, carry ripples toward theta.
            carry = 1'b1;
            for (int i = 0; i < 3; i++) begin
              if (carry) begin
                if (last[i]) begin
                  ax_d[i].cur = ax_q[i].lo;
                  ax_d[i].k   = '0;
                end else begin
                  ax_d[i].cur = nxt[i][ANG_W-1:0];
                  ax_d[i].k   = ax_q[i].k + 3'd1;
                  carry       = 1'b0;
                end
              end
            end
            if (carry) begin
              if (stage_q != '0 && cand_q != CW'(NUM_CAND - 1)) begin
                // Next candidate loads in the handshake cycle: no bubble.
                cand_d = cand_q + 1'b1;
                cword  = cand_word(buf_q, int'(cand_q) + 1);
                for (int i = 0; i < 3; i++) begin
                  ax_d[i] = load_axis(cword[ANG_W*i +: ANG_W], int'(stage_q));
                end
              end else if (stage_q == SW'(NUM_STAGE - 1)) begin
                state_d = DONE;
              end else begin
                state_d      = WAIT_SORT;
                stage_done_d = 1'b1;
              end
            end
          end
        end

        WAIT_SORT: begin
          if (sorted_rdy) begin
            state_d = SWEEP;
            buf_d   = candidate_angle_buffer;
            stage_d = stage_q + 1'b1;
            cand_d  = '0;
            cnt_d   = '0;
            step_d  = S0 >> (int'(stage_q) + 1);
            cword   = cand_word(candidate_angle_buffer, 0);
            for (int i = 0; i < 3; i++) begin
              ax_d[i] = load_axis(cword[ANG_W*i +: ANG_W], int'(stage_q) + 1);
            end
          end
        end

        DONE: state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ax_q         <= '0;
      step_q       <= '0;
      stage_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      stage_done_q <= 1'b0;
      // NOTE: the candidate latch is plain flops, not a RAM, so it is reset
      // along with the rest; it never powers up holding stale candidates.
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      ax_q         <= ax_d;
      step_q       <= step_d;
      stage_q      <= stage_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      stage_done_q <= stage_done_d;
      buf_q        <= buf_d;
    end
  end

  assign point_vld  = (state_q == SWEEP);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign stage_done = stage_done_q;
  assign theta      = ax_q[2].cur;
  assign phi        = ax_q[1].cur;
  assign alpha      = ax_q[0].cur;
  assign stage      = stage_q;
  assign cand_idx   = cand_q;
  assign point_cnt  = cnt_q;

endmodule

// File: tb/tb_attitude_search_seq.sv
// -----------------------------------------------------------------------------
// tb_attitude_search_seq
//
// Two instances share all inputs: inst 0 clamps window edges, inst 1 wraps.
// The driver pushes hand-listed expected points into one queue per instance;
// a negedge monitor compares every valid cycle against the queue head and
// pops on handshake, so held points must match the same head entry.
// -----------------------------------------------------------------------------
module tb_attitude_search_seq;

  localparam int AW = 12;
  localparam int NC = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              sorted_rdy = 1'b0;
  logic              point_rdy = 1'b0;
  logic [NC*3*AW-1:0] cab = '0;

  logic              vld [2];
  logic [AW-1:0]     th  [2];
  logic [AW-1:0]     ph  [2];
  logic [AW-1:0]     al  [2];
  logic [1:0]        stg [2];
  logic [3:0]        cid [2];
  logic [15:0]       pc  [2];
  logic              sd  [2];
  logic              dn  [2];
  logic              bsy [2];

  typedef struct {
    int t; int p; int a; int s; int c; int n;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  int   lists [3][16];
  int   lens  [3];
  int   errors = 0;
  int   checks = 0;
  int   sd_cnt [2] = '{0, 0};
  int   dn_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  attitude_search_seq #(.WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sorted_rdy(sorted_rdy), .candidate_angle_buffer(cab),
    .point_rdy(point_rdy), .point_vld(vld[0]),
    .theta(th[0]), .phi(ph[0]), .alpha(al[0]),
    .stage(stg[0]), .cand_idx(cid[0]), .point_cnt(pc[0]),
    .stage_done(sd[0]), .done(dn[0]), .busy(bsy[0])
  );

  attitude_search_seq #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sorted_rdy(sorted_rdy), .candidate_angle_buffer(cab),
    .point_rdy(point_rdy), .point_vld(vld[1]),
    .theta(th[1]), .phi(ph[1]), .alpha(al[1]),
    .stage(stg[1]), .cand_idx(cid[1]), .point_cnt(pc[1]),
    .stage_done(sd[1]), .done(dn[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_point(input int id);
    exp_t e;
    bit   have;
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL point[%0d]: got (%0d,%0d,%0d) cnt=%0d, expected no point",
               id, th[id], ph[id], al[id], pc[id]);
      return;
    end
    e = (id == 0) ? q0[0] : q1[0];
    if (int'(th[id]) != e.t || int'(ph[id]) != e.p || int'(al[id]) != e.a ||
        int'(stg[id]) != e.s || int'(cid[id]) != e.c || int'(pc[id]) != e.n) begin
      errors++;
      $display("FAIL point[%0d]: got (%0d,%0d,%0d) stage=%0d cand=%0d cnt=%0d, expected (%0d,%0d,%0d) stage=%0d cand=%0d cnt=%0d",
               id, th[id], ph[id], al[id], stg[id], cid[id], pc[id],
               e.t, e.p, e.a, e.s, e.c, e.n);
    end
    if (point_rdy) begin
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (sd[id]) sd_cnt[id]++;
      if (dn[id]) dn_cnt[id]++;
      if (rst && vld[id]) mon_point(id);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set5(input int ax, input int v0, input int v1, input int v2,
                      input int v3, input int v4);
    lists[ax][0] = v0; lists[ax][1] = v1; lists[ax][2] = v2;
    lists[ax][3] = v3; lists[ax][4] = v4; lens[ax] = 5;
  endtask

  task automatic set3(input int ax, input int v0, input int v1, input int v2);
    lists[ax][0] = v0; lists[ax][1] = v1; lists[ax][2] = v2; lens[ax] = 3;
  endtask

  task automatic push_cand(input int id, input int s, input int c, inout int n);
    exp_t e;
    for (int i = 0; i < lens[0]; i++)
      for (int j = 0; j < lens[1]; j++)
        for (int k = 0; k < lens[2]; k++) begin
          e.t = lists[0][i]; e.p = lists[1][j]; e.a = lists[2][k];
          e.s = s; e.c = c; e.n = n;
          n++;
          if (id == 0) q0.push_back(e);
          else         q1.push_back(e);
        end
  endtask

  task automatic set_cand(input int idx, input int t, input int p, input int a);
    cab[3*AW*idx +: 3*AW] = {AW'(t), AW'(p), AW'(a)};
  endtask

  task automatic check_zero(input string name);
    for (int id = 0; id < 2; id++) begin
      check({name, "_ctl"}, int'({vld[id], bsy[id], sd[id], dn[id]}), 0);
      check({name, "_theta"}, int'(th[id]), 0);
      check({name, "_phi"}, int'(ph[id]), 0);
      check({name, "_alpha"}, int'(al[id]), 0);
      check({name, "_point_cnt"}, int'(pc[id]), 0);
    end
  endtask

  task automatic push_stage0();
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int ax = 0; ax < 3; ax++) begin
      lens[ax] = 16;
      for (int i = 0; i < 16; i++) lists[ax][i] = 256 * i;
    end
    push_cand(0, 0, 0, n0);
    push_cand(1, 0, 0, n1);
  endtask

  // Full stage 0 with point_rdy held high; ends in WAIT_SORT.
  task automatic run_stage0();
    int cyc;
    push_stage0();
    point_rdy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_point_latency0", int'(vld[0]), 1);
    check("first_point_latency1", int'(vld[1]), 1);
    cyc = 0;
    while (!sd[0] && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("stage0_done_cycle", cyc, 4096);
    check("stage0_done_wrap", int'(sd[1]), 1);
    check("stage0_vld_low", int'(vld[0]), 0);
    tick();
    check("stage0_queue0_empty", q0.size(), 0);
    check("stage0_queue1_empty", q1.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n0, n1;

    // Reset, then idle with start low.
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (10) begin
      tick();
      for (int id = 0; id < 2; id++)
        check("idle_ctl", int'({vld[id], bsy[id], sd[id], dn[id]}), 0);
    end
    check_zero("idle");

    // Stage 0 coarse grid.
    run_stage0();

    // Stage 1: every candidate at 2048, random backpressure, a stray
    // sorted_rdy mid-sweep with a different buffer that must be ignored.
    for (int i = 0; i < NC; i++) set_cand(i, 2048, 2048, 2048);
    for (int ax = 0; ax < 3; ax++) set5(ax, 1792, 1920, 2048, 2176, 2304);
    n0 = 0; n1 = 0;
    for (int c = 0; c < NC; c++) begin
      push_cand(0, 1, c, n0);
      push_cand(1, 1, c, n1);
    end
    sorted_rdy = 1'b1;
    tick();
    sorted_rdy = 1'b0;
    cab = '0;
    check("stage1_vld", int'(vld[0]), 1);
    cyc = 0;
    while (!sd[0] && cyc < 8000) begin
      point_rdy  = 1'($urandom_range(0, 1));
      sorted_rdy = (cyc == 300);
      tick();
      cyc++;
    end
    sorted_rdy = 1'b0;
    point_rdy  = 1'b1;
    check("stage1_done_seen", int'(sd[0]), 1);
    check("stage1_done_wrap", int'(sd[1]), 1);
    check("stage1_point_cnt", int'(pc[0]), 1250);
    tick();
    check("stage1_queue0_empty", q0.size(), 0);
    check("stage1_queue1_empty", q1.size(), 0);

    // Stage 2 (final): candidate i centred at (1000+100i, 2000, 3000).
    n0 = 0; n1 = 0;
    for (int c = 0; c < NC; c++) begin
      set_cand(c, 1000 + 100 * c, 2000, 3000);
      set5(0, 872 + 100 * c, 936 + 100 * c, 1000 + 100 * c, 1064 + 100 * c, 1128 + 100 * c);
      set5(1, 1872, 1936, 2000, 2064, 2128);
      set5(2, 2872, 2936, 3000, 3064, 3128);
      push_cand(0, 2, c, n0);
      push_cand(1, 2, c, n1);
    end
    sorted_rdy = 1'b1;
    tick();
    sorted_rdy = 1'b0;
    cyc = 0;
    while (!dn[0] && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("final_done_seen", int'(dn[0]), 1);
    check("final_done_wrap", int'(dn[1]), 1);
    check("final_busy_during_done", int'(bsy[0]), 1);
    tick();
    check("final_busy_after_done", int'(bsy[0]), 0);
    check("final_done_cleared", int'(dn[0]), 0);
    repeat (5) tick();
    check("done_pulses0", dn_cnt[0], 1);
    check("done_pulses1", dn_cnt[1], 1);
    check("stage_done_pulses", sd_cnt[0], 2);
    check("final_queue0_empty", q0.size(), 0);
    check("final_queue1_empty", q1.size(), 0);

    // Edge window: candidate 0 at (0,0,4095), then abort mid stage 1.
    run_stage0();
    for (int i = 0; i < NC; i++) set_cand(i, 2048, 2048, 2048);
    set_cand(0, 0, 0, 4095);
    set_cand(1, 1024, 1024, 1024);
    n0 = 0; n1 = 0;
    set3(0, 0, 128, 256);
    set3(1, 0, 128, 256);
    set3(2, 3839, 3967, 4095);
    push_cand(0, 1, 0, n0);
    set5(0, 3840, 3968, 0, 128, 256);
    set5(1, 3840, 3968, 0, 128, 256);
    set5(2, 3839, 3967, 4095, 127, 255);
    push_cand(1, 1, 0, n1);
    for (int ax = 0; ax < 3; ax++) set5(ax, 768, 896, 1024, 1152, 1280);
    push_cand(0, 1, 1, n0);
    push_cand(1, 1, 1, n1);
    for (int ax = 0; ax < 3; ax++) set5(ax, 1792, 1920, 2048, 2176, 2304);
    push_cand(0, 1, 2, n0);
    push_cand(1, 1, 2, n1);
    sorted_rdy = 1'b1;
    tick();
    sorted_rdy = 1'b0;
    repeat (200) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_left0", q0.size(), 277 - 201);
    check("abort_left1", q1.size(), 375 - 201);
    check_zero("abort");
    q0.delete();
    q1.delete();
    repeat (3) tick();
    check("abort_no_done", dn_cnt[0], 1);
    check("abort_no_stage_done", sd_cnt[0], 3);

    // Asynchronous reset mid-sweep, then a fresh run from stage 0.
    push_stage0();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b1;
    tick();
    push_stage0();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_vld", int'(vld[0]), 1);
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("restart_left0", q0.size(), 4096 - 21);
    q0.delete();
    q1.delete();
    tick();
    check("restart_idle", int'(bsy[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
